// File: rtl/modport_mem_pkg.sv
// Shared sizes and types for the 4x8 register memory.
// DEPTH is tied to ADDR_WIDTH so every address value names a real word.
package modport_mem_pkg;
  localparam int ADDR_WIDTH = 2;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef data_t [DEPTH-1:0]     mem_t;
endpackage

// File: rtl/modport_mem_if.sv
// Access bus for modport_mem: the master drives address, enables and write data.
// The slave returns registered read data; there is no backpressure.
interface modport_mem_if;
  import modport_mem_pkg::*;

  addr_t addr;
  logic  wr_en;
  logic  rd_en;
  data_t wdata;
  data_t rdata;

  modport master (
    output addr,
    output wr_en,
    output rd_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  rd_en,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/modport_mem_array.sv
// Storage array: synchronous write, registered read, synchronous clear.
// Read data is valid one cycle after re; same-address write+read returns old contents.
module modport_mem_array
  import modport_mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  logic  re,
  input  addr_t addr,
  input  data_t wdata,
  output data_t rdata
);

  mem_t mem;

  // Both updates use the pre-edge mem contents, which gives read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem   <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/modport_mem.sv
// 4x8 single-port register memory behind a modport bus; 1-cycle read latency, no backpressure.
// rdata holds its last value when no read is issued.
module modport_mem
  import modport_mem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  modport_mem_if.slave  bus
);

  logic  we;
  logic  re;
  data_t rdata;

  // Reset aborts any access presented in the same cycle.
  assign we = bus.wr_en & ~reset;
  assign re = bus.rd_en & ~reset;

  modport_mem_array u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .re    (re),
    .addr  (bus.addr),
    .wdata (bus.wdata),
    .rdata (rdata)
  );

  assign bus.rdata = rdata;

endmodule

// File: tb/tb_modport_mem.sv
// Directed bench for modport_mem: inputs change 1 unit after posedge, rdata checked 1 unit after.
module tb_modport_mem;
  import modport_mem_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  modport_mem_if bus ();

  modport_mem dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic w, input logic rd, input addr_t a, input data_t d);
    reset     = r;
    bus.wr_en = w;
    bus.rd_en = rd;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input data_t exp);
    tests++;
    assert (bus.rdata === exp)
    else begin
      fails++;
      $error("FAIL %s: rdata=%h expected %h", tag, bus.rdata, exp);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset for two cycles, then read every word back as zero.
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    check("reset_rdata", 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 8'h00); check("reset_rd0", 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00); check("reset_rd1", 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 8'h00); check("reset_rd2", 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 2'd3, 8'h00); check("reset_rd3", 8'h00);

    // Fill all words, then read them back-to-back.
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h11);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h22);
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 8'h33);
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h44);
    check("no_read_during_writes", 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 8'h00); check("rd_addr0", 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00); check("rd_addr1", 8'h22);
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 8'h00); check("rd_addr2", 8'h33);
    cyc(1'b0, 1'b0, 1'b1, 2'd3, 8'h00); check("rd_addr3", 8'h44);

    // rdata holds while only writes happen.
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'hFF); check("hold_1", 8'h44);
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'hFF); check("hold_2", 8'h44);
    cyc(1'b0, 1'b0, 1'b0, 2'd3, 8'h00); check("hold_3", 8'h44);
    cyc(1'b0, 1'b0, 1'b1, 2'd3, 8'h00); check("rd_addr3_new", 8'hFF);

    // Same-address write and read returns the old contents.
    cyc(1'b0, 1'b1, 1'b1, 2'd2, 8'hA5); check("rdw_old", 8'h33);
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 8'h00); check("rdw_new", 8'hA5);

    // Reset with a write pending: write dropped, everything cleared.
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'h5A); check("midrst_rdata", 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00); check("midrst_addr1", 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 8'h00); check("midrst_addr2", 8'h00);

    // Consecutive writes to one address: the last one wins.
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h0F);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'hF0);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 8'h00); check("overwrite", 8'hF0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00); check("overwrite_hold", 8'hF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
